// File: rtl/extend_pkg.sv
// Shared types and constants for the handshaked immediate extend unit.
package extend_pkg;

    typedef enum logic [2:0] {
        SRC_DP  = 3'd0,
        SRC_MEM = 3'd1,
        SRC_BR  = 3'd2,
        SRC_SH  = 3'd3,
        SRC_HW  = 3'd4,
        SRC_RSV = 3'd7
    } imm_src_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int ROT_FIELD_LSB = 8;
    // Enough for the largest rotate (30) and its cycle count at STEP=1.
    localparam int CNT_W = 5;

    // Codes 5..7 all collapse onto the reserved mode.
    function automatic imm_src_e decode_src(input logic [2:0] raw);
        case (raw)
            3'd0:    return SRC_DP;
            3'd1:    return SRC_MEM;
            3'd2:    return SRC_BR;
            3'd3:    return SRC_SH;
            3'd4:    return SRC_HW;
            default: return SRC_RSV;
        endcase
    endfunction

endpackage

// File: rtl/extend_seq_ror_step.sv
// Combinational rotate-right of a WIDTH-bit word by 0..STEP positions.
module ror_step
    import extend_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int AW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [AW-1:0]    amt,
    output logic [WIDTH-1:0] result
);

    logic [2*WIDTH-1:0] dbl;
    logic [WIDTH-1:0]   cand [STEP+1];

    assign dbl = {data, data};

    generate
        for (genvar gi = 0; gi <= STEP; gi++) begin : g_cand
            assign cand[gi] = dbl[gi +: WIDTH];
        end
    endgenerate

    always_comb begin
        result = data;
        for (int i = 0; i <= STEP; i++) begin
            if (int'(amt) == i) begin
                result = cand[i];
            end
        end
    end

endmodule

// File: rtl/extend_seq.sv
// Handshaked immediate extend unit with an iterative DP rotator.
// Define EXTEND_FAST_ROT_EN to replace the iterative rotate with a one-cycle barrel rotate.
module extend_seq
    import extend_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IMM_W = 24,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IMM_W-1:0] imm,
    input  logic [2:0]       imm_src,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] imm_ext,
    output logic             c_out,
    output logic             src_err
);

    localparam int AW = $clog2(STEP + 1);

    state_e           state_reg, state_next;
    logic [WIDTH-1:0] ext_reg, ext_next;
    logic             c_out_reg, c_out_next;
    logic             err_reg, err_next;

    imm_src_e         src;
    logic [CNT_W-1:0] rot_amt;
    logic [WIDTH-1:0] byte_ext;
    logic [WIDTH-1:0] direct_ext;
    logic             direct_c;
    logic             direct_err;

    assign src      = decode_src(imm_src);
    assign rot_amt  = {imm[ROT_FIELD_LSB+3:ROT_FIELD_LSB], 1'b0};
    assign byte_ext = {{(WIDTH-8){1'b0}}, imm[7:0]};

`ifdef EXTEND_FAST_ROT_EN
    logic [2*WIDTH-1:0] dbl_byte;
    logic [WIDTH-1:0]   fast_rot;

    assign dbl_byte = {byte_ext, byte_ext};
    assign fast_rot = dbl_byte[rot_amt +: WIDTH];
    assign direct_c = (src == SRC_DP && rot_amt != '0) ? fast_rot[WIDTH-1] : c_in;
`else
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] rem_reg, rem_next;
    logic [WIDTH-1:0] rot_reg, rot_next;
    logic [AW-1:0]    step_amt;
    logic [WIDTH-1:0] rot_step;

    // The last step only covers whatever rotation is left over.
    assign step_amt = (int'(rem_reg) >= STEP) ? AW'(STEP) : AW'(rem_reg);

    ror_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .AW    (AW)
    ) u_ror_step (
        .data   (rot_reg),
        .amt    (step_amt),
        .result (rot_step)
    );

    assign direct_c = c_in;
`endif

    always_comb begin
        direct_ext = '0;
        case (src)
`ifdef EXTEND_FAST_ROT_EN
            SRC_DP:  direct_ext = fast_rot;
`else
            SRC_DP:  direct_ext = byte_ext;
`endif
            SRC_MEM: direct_ext = {{(WIDTH-12){1'b0}}, imm[11:0]};
            SRC_BR:  direct_ext = {{(WIDTH-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
            SRC_SH:  direct_ext = {{(WIDTH-5){1'b0}}, imm[11:7]};
            SRC_HW:  direct_ext = {{(WIDTH-8){1'b0}}, imm[11:8], imm[3:0]};
            default: direct_ext = '0;
        endcase
    end

    assign direct_err = (src == SRC_RSV);

    always_comb begin
        state_next = state_reg;
        ext_next   = ext_reg;
        c_out_next = c_out_reg;
        err_next   = err_reg;
`ifndef EXTEND_FAST_ROT_EN
        cnt_next   = cnt_reg;
        rem_next   = rem_reg;
        rot_next   = rot_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
`ifndef EXTEND_FAST_ROT_EN
                    if (src == SRC_DP && rot_amt != '0) begin
                        rot_next   = byte_ext;
                        rem_next   = rot_amt;
                        cnt_next   = CNT_W'((int'(rot_amt) + STEP - 1) / STEP);
                        state_next = ROT;
                    end else
`endif
                    begin
                        ext_next   = direct_ext;
                        c_out_next = direct_c;
                        err_next   = direct_err;
                        state_next = HOLD;
                    end
                end
            end
`ifndef EXTEND_FAST_ROT_EN
            ROT: begin
                rot_next = rot_step;
                rem_next = rem_reg - CNT_W'(step_amt);
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == CNT_W'(1)) begin
                    ext_next   = rot_step;
                    c_out_next = rot_step[WIDTH-1];
                    err_next   = 1'b0;
                    state_next = HOLD;
                end
            end
`endif
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ext_reg   <= '0;
            c_out_reg <= 1'b0;
            err_reg   <= 1'b0;
`ifndef EXTEND_FAST_ROT_EN
            cnt_reg   <= '0;
            rem_reg   <= '0;
            rot_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            ext_reg   <= ext_next;
            c_out_reg <= c_out_next;
            err_reg   <= err_next;
`ifndef EXTEND_FAST_ROT_EN
            cnt_reg   <= cnt_next;
            rem_reg   <= rem_next;
            rot_reg   <= rot_next;
`endif
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == HOLD);
    assign imm_ext   = ext_reg;
    assign c_out     = c_out_reg;
    assign src_err   = err_reg;

endmodule

// File: tb/tb_extend_seq.sv
// Directed plus randomized bench for extend_seq against an arithmetic reference model.
module tb_extend_seq;

    localparam int WIDTH = 32;
    localparam int IMM_W = 24;
    localparam int STEP  = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [IMM_W-1:0] imm;
    logic [2:0]       imm_src;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] imm_ext;
    logic             c_out;
    logic             src_err;

    int n_assert = 0;
    int n_fail   = 0;

    extend_seq #(
        .WIDTH (WIDTH),
        .IMM_W (IMM_W),
        .STEP  (STEP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm       (imm),
        .imm_src   (imm_src),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .imm_ext   (imm_ext),
        .c_out     (c_out),
        .src_err   (src_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: rotation done one bit at a time with plain arithmetic.
    function automatic void model(input logic [23:0] a_imm, input logic [2:0] a_src, input logic a_cin,
                                  output logic [31:0] e_ext, output logic e_c, output logic e_err,
                                  output int e_n);
        longint v;
        int     r;
        v     = 0;
        r     = 0;
        e_c   = a_cin;
        e_err = 1'b0;
        e_n   = 0;
        case (int'(a_src))
            0: begin
                v = longint'(a_imm) % 256;
                r = ((int'(a_imm) / 256) % 16) * 2;
                for (int k = 0; k < r; k++) begin
                    v = (v / 2) + (v % 2) * (64'sd1 << 31);
                end
                if (r != 0) e_c = ((v >> 31) % 2) == 1;
`ifdef EXTEND_FAST_ROT_EN
                e_n = 0;
`else
                e_n = (r + STEP - 1) / STEP;
`endif
            end
            1: v = longint'(a_imm) % 4096;
            2: begin
                v = longint'(a_imm);
                if (v >= (64'sd1 << 23)) v = v - (64'sd1 << 24);
                v = v * 4;
            end
            3: v = (longint'(a_imm) / 128) % 32;
            4: v = ((longint'(a_imm) / 256) % 16) * 16 + longint'(a_imm) % 16;
            default: begin
                v     = 0;
                e_err = 1'b1;
            end
        endcase
        e_ext = 32'(v);
    endfunction

    task automatic run_req(input logic [23:0] a_imm, input logic [2:0] a_src, input logic a_cin,
                           input int stall);
        logic [31:0] e_ext;
        logic        e_c;
        logic        e_err;
        int          e_n;
        int          lat;
        model(a_imm, a_src, a_cin, e_ext, e_c, e_err, e_n);
        @(negedge clk);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        imm      = a_imm;
        imm_src  = a_src;
        c_in     = a_cin;
        in_valid = 1'b1;
        @(negedge clk);
        // Scramble request inputs so any late sampling shows up.
        in_valid = 1'b0;
        imm      = IMM_W'($urandom);
        imm_src  = 3'($urandom);
        c_in     = 1'($urandom);
        lat      = 1;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'(1 + e_n));
        check("imm_ext", 64'(imm_ext), 64'(e_ext));
        check("c_out", 64'(c_out), 64'(e_c));
        check("src_err", 64'(src_err), 64'(e_err));
        for (int k = 0; k < stall; k++) begin
            in_valid = 1'b1;
            @(negedge clk);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_imm_ext", 64'(imm_ext), 64'(e_ext));
            check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_out_valid", 64'(out_valid), 64'd0);
        check("release_in_ready", 64'(in_ready), 64'd1);
        $display("req imm=0x%06h src=%0d c_in=%0b -> ext=0x%08h c_out=%0b err=%0b lat=%0d stall=%0d",
                 a_imm, a_src, a_cin, e_ext, e_c, e_err, lat, stall);
    endtask

    initial begin
        logic [23:0] r_imm;
        logic [2:0]  r_src;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        imm       = '0;
        imm_src   = '0;
        c_in      = 1'b0;
        out_ready = 1'b0;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_imm_ext", 64'(imm_ext), 64'd0);
        check("rst_c_out", 64'(c_out), 64'd0);
        check("rst_src_err", 64'(src_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_req(24'h0002FF, 3'd0, 1'b0, 0);
        run_req(24'h000F01, 3'd0, 1'b0, 0);
        run_req(24'hFFFFFE, 3'd2, 1'b1, 0);
        run_req(24'h123ABC, 3'd1, 1'b1, 0);
        run_req(24'h000F80, 3'd3, 1'b1, 0);
        run_req(24'h000A05, 3'd4, 1'b1, 0);
        run_req(24'h000000, 3'd6, 1'b1, 0);
        run_req(24'h0000A5, 3'd0, 1'b1, 0);
        run_req(24'h123ABC, 3'd1, 1'b0, 5);

        // Asynchronous reset while a long rotate is in flight.
        @(negedge clk);
        imm      = 24'h000F01;
        imm_src  = 3'd0;
        c_in     = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_imm_ext", 64'(imm_ext), 64'd0);
        check("async_c_out", 64'(c_out), 64'd0);
        check("async_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_req(24'h0002FF, 3'd0, 1'b0, 0);

        for (int t = 0; t < 40; t++) begin
            r_imm = 24'($urandom);
            r_src = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) r_src = 3'd0;
            run_req(r_imm, r_src, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
